// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: default table sizes and the register-status entry.
package ooo_pkg;

    localparam int DEF_NUM_REGS  = 32;
    localparam int DEF_ROB_DEPTH = 16;
    localparam int DEF_NUM_CKPT  = 4;

    localparam int REG_IDX_W  = $clog2(DEF_NUM_REGS);
    localparam int ROB_IDX_W  = $clog2(DEF_ROB_DEPTH);
    localparam int CKPT_IDX_W = $clog2(DEF_NUM_CKPT);

    // Entries are stored flattened as {busy, rob}; this struct names that layout.
    typedef struct packed {
        logic                 busy;
        logic [ROB_IDX_W-1:0] rob;
    } reg_stat_t;

endpackage

// File: rtl/regstat_ckpt_bank.sv
// Branch checkpoint slots for the register status table.
// Committing instructions are scrubbed from every slot so a restored image never resurrects them.
module regstat_ckpt_bank
    import ooo_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int ROB_DEPTH = DEF_ROB_DEPTH,
    parameter int NUM_CKPT  = DEF_NUM_CKPT
) (
    input  logic                                            i_clk,
    input  logic                                            i_reset_n,
    input  logic                                            i_flush,
    input  logic                                            i_commit_valid,
    input  logic [$clog2(NUM_REGS)-1:0]                     i_commit_dest,
    input  logic [$clog2(ROB_DEPTH)-1:0]                    i_commit_rob,
    input  logic                                            i_save,
    input  logic [$clog2(NUM_CKPT)-1:0]                     i_save_id,
    input  logic [NUM_REGS-1:0][$clog2(ROB_DEPTH):0]        i_save_image,
    input  logic [$clog2(NUM_CKPT)-1:0]                     i_restore_id,
    output logic [NUM_REGS-1:0][$clog2(ROB_DEPTH):0]        o_restore_image
);

    localparam int REG_W  = $clog2(NUM_REGS);
    localparam int ROB_W  = $clog2(ROB_DEPTH);
    localparam int CKPT_W = $clog2(NUM_CKPT);
    localparam int ENT_W  = ROB_W + 1;

    logic [NUM_CKPT-1:0][NUM_REGS-1:0][ENT_W-1:0] r_slot;
    logic [NUM_CKPT-1:0][NUM_REGS-1:0][ENT_W-1:0] w_cleared;
    logic [NUM_CKPT-1:0][NUM_REGS-1:0][ENT_W-1:0] w_slot_next;

    // Register 0 is never busy in any image, so the scrub starts at 1.
    always_comb begin
        w_cleared = r_slot;
        for (int s = 0; s < NUM_CKPT; s++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (i_commit_valid && i_commit_dest == REG_W'(r) &&
                    r_slot[s][r][ROB_W-1:0] == i_commit_rob) begin
                    w_cleared[s][r] = '0;
                end
            end
        end
    end

    assign o_restore_image = w_cleared[i_restore_id];

    always_comb begin
        w_slot_next = w_cleared;
        for (int s = 0; s < NUM_CKPT; s++) begin
            if (i_save && i_save_id == CKPT_W'(s)) begin
                w_slot_next[s] = i_save_image;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_slot <= '0;
        end else if (i_flush) begin
            r_slot <= '0;
        end else begin
            r_slot <= w_slot_next;
        end
    end

endmodule

// File: rtl/regstat_ckpt.sv
// Register status table (producer ROB tag per architectural register) for an OoO core.
// Define REGSTAT_CKPT_EN to add branch checkpoint save/restore; otherwise recovery is flush-only.
module regstat_ckpt
    import ooo_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int ROB_DEPTH = DEF_ROB_DEPTH,
    parameter int NUM_CKPT  = DEF_NUM_CKPT
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic                             issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0]      issue_dest,
    input  logic [$clog2(ROB_DEPTH)-1:0]     issue_rob,
    input  logic                             commit_valid,
    input  logic [$clog2(NUM_REGS)-1:0]      commit_dest,
    input  logic [$clog2(ROB_DEPTH)-1:0]     commit_rob,
    input  logic [$clog2(NUM_REGS)-1:0]      rs1,
    input  logic [$clog2(NUM_REGS)-1:0]      rs2,
`ifdef REGSTAT_CKPT_EN
    input  logic                             ckpt_save,
    input  logic [$clog2(NUM_CKPT)-1:0]      ckpt_save_id,
    input  logic                             ckpt_restore,
    input  logic [$clog2(NUM_CKPT)-1:0]      ckpt_restore_id,
`endif
    output logic [$clog2(ROB_DEPTH)-1:0]     q_j,
    output logic [$clog2(ROB_DEPTH)-1:0]     q_k,
    output logic                             busy_j,
    output logic                             busy_k
);

    localparam int REG_W = $clog2(NUM_REGS);
    localparam int ROB_W = $clog2(ROB_DEPTH);
    localparam int ENT_W = ROB_W + 1;

    logic [NUM_REGS-1:0][ENT_W-1:0] r_table;
    logic [NUM_REGS-1:0][ENT_W-1:0] w_updated;
    logic [NUM_REGS-1:0][ENT_W-1:0] w_next;

    // A commit only frees the register if no younger instruction has since renamed it.
    always_comb begin
        w_updated = r_table;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (commit_valid && commit_dest == REG_W'(r) &&
                r_table[r][ROB_W-1:0] == commit_rob) begin
                w_updated[r] = '0;
            end
            if (issue_valid && issue_dest == REG_W'(r)) begin
                w_updated[r] = {1'b1, issue_rob};
            end
        end
    end

    always_comb begin
        busy_j = r_table[rs1][ROB_W];
        q_j    = r_table[rs1][ROB_W-1:0];
        busy_k = r_table[rs2][ROB_W];
        q_k    = r_table[rs2][ROB_W-1:0];
        if (commit_valid && commit_dest == rs1 && q_j == commit_rob) begin
            busy_j = 1'b0;
        end
        if (commit_valid && commit_dest == rs2 && q_k == commit_rob) begin
            busy_k = 1'b0;
        end
    end

`ifdef REGSTAT_CKPT_EN
    logic [NUM_REGS-1:0][ENT_W-1:0] w_restored;

    regstat_ckpt_bank #(
        .NUM_REGS  (NUM_REGS),
        .ROB_DEPTH (ROB_DEPTH),
        .NUM_CKPT  (NUM_CKPT)
    ) u_bank (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_flush         (flush),
        .i_commit_valid  (commit_valid),
        .i_commit_dest   (commit_dest),
        .i_commit_rob    (commit_rob),
        .i_save          (ckpt_save),
        .i_save_id       (ckpt_save_id),
        .i_save_image    (w_next),
        .i_restore_id    (ckpt_restore_id),
        .o_restore_image (w_restored)
    );

    // A restore discards this cycle's issue; saving w_next captures the restored image.
    assign w_next = ckpt_restore ? w_restored : w_updated;
`else
    assign w_next = w_updated;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_table <= '0;
        end else if (flush) begin
            r_table <= '0;
        end else begin
            r_table <= w_next;
        end
    end

endmodule

// File: tb/tb_regstat_ckpt.sv
// Scoreboard testbench for regstat_ckpt; checkpoint scenarios run when REGSTAT_CKPT_EN is defined.
module tb_regstat_ckpt;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       issueValid;
    logic [4:0] issueDest;
    logic [3:0] issueRob;
    logic       commitValid;
    logic [4:0] commitDest;
    logic [3:0] commitRob;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       ckptSave;
    logic [1:0] ckptSaveId;
    logic       ckptRestore;
    logic [1:0] ckptRestoreId;
    logic [3:0] qJ;
    logic [3:0] qK;
    logic       busyJ;
    logic       busyK;

    logic       pendFlush     = 1'b0;
    logic       pendSave      = 1'b0;
    logic [1:0] pendSaveId    = '0;
    logic       pendRestore   = 1'b0;
    logic [1:0] pendRestoreId = '0;

    typedef struct {
        string      tag;
        logic [4:0] expJ;
        logic [4:0] expK;
    } exp_t;

    exp_t sbQueue[$];
    int   total = 0;
    int   bad   = 0;

    logic       mBusy [32];
    logic [3:0] mRob  [32];

    always #5 clk = ~clk;

    regstat_ckpt dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .issue_valid     (issueValid),
        .issue_dest      (issueDest),
        .issue_rob       (issueRob),
        .commit_valid    (commitValid),
        .commit_dest     (commitDest),
        .commit_rob      (commitRob),
        .rs1             (rs1),
        .rs2             (rs2),
`ifdef REGSTAT_CKPT_EN
        .ckpt_save       (ckptSave),
        .ckpt_save_id    (ckptSaveId),
        .ckpt_restore    (ckptRestore),
        .ckpt_restore_id (ckptRestoreId),
`endif
        .q_j             (qJ),
        .q_k             (qK),
        .busy_j          (busyJ),
        .busy_k          (busyK)
    );

    task automatic checkOutput(input string tag, input logic [4:0] actual, input logic [4:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got busy/q=%h expected %h", tag, actual, expected);
        end
    endtask

    // Pops the oldest expectation and compares it against the combinational read ports.
    task automatic sampleCheck();
        exp_t e;
        #1;
        if (sbQueue.size() == 0) begin
            checkOutput("queue_empty", 5'h1f, 5'h00);
        end else begin
            e = sbQueue.pop_front();
            checkOutput({e.tag, "_j"}, {busyJ, qJ}, e.expJ);
            checkOutput({e.tag, "_k"}, {busyK, qK}, e.expK);
        end
    endtask

    // Drives one cycle of inputs, queues the expected pre-edge reads and checks them.
    task automatic applyStimulus(input string tag,
                                 input logic iv, input logic [4:0] id, input logic [3:0] ir,
                                 input logic cv, input logic [4:0] cd, input logic [3:0] cr,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [4:0] expJ, input logic [4:0] expK);
        exp_t e;
        issueValid    = iv;  issueDest  = id;  issueRob  = ir;
        commitValid   = cv;  commitDest = cd;  commitRob = cr;
        rs1           = s1;  rs2        = s2;
        flush         = pendFlush;
        ckptSave      = pendSave;    ckptSaveId    = pendSaveId;
        ckptRestore   = pendRestore; ckptRestoreId = pendRestoreId;
        pendFlush     = 1'b0;
        pendSave      = 1'b0;
        pendRestore   = 1'b0;
        e.tag  = tag;
        e.expJ = expJ;
        e.expK = expK;
        sbQueue.push_back(e);
        sampleCheck();
        @(negedge clk);
    endtask

    function automatic logic [4:0] modelRead(input logic [4:0] idx, input logic cv,
                                             input logic [4:0] cd, input logic [3:0] cr);
        logic b;
        if (idx == 5'd0) return 5'd0;
        b = mBusy[idx];
        if (cv && cd == idx && mRob[idx] == cr) b = 1'b0;
        return {b, mRob[idx]};
    endfunction

    initial begin
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            mBusy[i] = 1'b0;
            mRob[i]  = '0;
        end
        flush = 1'b0; issueValid = 1'b0; issueDest = '0; issueRob = '0;
        commitValid = 1'b0; commitDest = '0; commitRob = '0;
        ckptSave = 1'b0; ckptSaveId = '0; ckptRestore = 1'b0; ckptRestoreId = '0;
        rs1 = 5'd5; rs2 = 5'd31;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        e.tag = "reset"; e.expJ = 5'h00; e.expK = 5'h00;
        sbQueue.push_back(e);
        sampleCheck();
        @(negedge clk);
        reset_n = 1'b1;

        // Issue, read, commit with bypass, then cleared
        applyStimulus("iss5",      1, 5'd5, 4'd3, 0, 5'd0, 4'd0, 5'd5, 5'd0, 5'h00, 5'h00);
        applyStimulus("read5",     0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd5, 5'd5, 5'h13, 5'h13);
        applyStimulus("byp5",      0, 5'd0, 4'd0, 1, 5'd5, 4'd3, 5'd5, 5'd5, 5'h03, 5'h03);
        applyStimulus("clr5",      0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd5, 5'd0, 5'h00, 5'h00);
        // Stale commit must not free a renamed register
        applyStimulus("iss7a",     1, 5'd7, 4'd2, 0, 5'd0, 4'd0, 5'd7, 5'd0, 5'h00, 5'h00);
        applyStimulus("iss7b",     1, 5'd7, 4'd9, 0, 5'd0, 4'd0, 5'd7, 5'd0, 5'h12, 5'h00);
        applyStimulus("stale7",    0, 5'd0, 4'd0, 1, 5'd7, 4'd2, 5'd7, 5'd0, 5'h19, 5'h00);
        applyStimulus("keep7",     0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd7, 5'd0, 5'h19, 5'h00);
        // Issue beats commit on the same register
        applyStimulus("iss4a",     1, 5'd4, 4'd1, 0, 5'd0, 4'd0, 5'd4, 5'd0, 5'h00, 5'h00);
        applyStimulus("issCmt4",   1, 5'd4, 4'd6, 1, 5'd4, 4'd1, 5'd4, 5'd7, 5'h01, 5'h19);
        applyStimulus("prio4",     0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd4, 5'd7, 5'h16, 5'h19);
        // Register zero is never busy
        applyStimulus("iss0",      1, 5'd0, 4'd5, 0, 5'd0, 4'd0, 5'd0, 5'd0, 5'h00, 5'h00);
        applyStimulus("read0",     0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd0, 5'd0, 5'h00, 5'h00);
        // Flush wins over a same-cycle issue
        pendFlush = 1'b1;
        applyStimulus("flush",     1, 5'd2, 4'd1, 0, 5'd0, 4'd0, 5'd7, 5'd4, 5'h19, 5'h16);
        applyStimulus("postFl_a",  0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd7, 5'd2, 5'h00, 5'h00);
        applyStimulus("postFl_b",  0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd4, 5'd5, 5'h00, 5'h00);

`ifdef REGSTAT_CKPT_EN
        pendSave = 1'b1; pendSaveId = 2'd1;
        applyStimulus("ckSave1",   1, 5'd3, 4'd4, 0, 5'd0, 4'd0, 5'd3, 5'd0, 5'h00, 5'h00);
        applyStimulus("ckIss3",    1, 5'd3, 4'd8, 0, 5'd0, 4'd0, 5'd3, 5'd0, 5'h14, 5'h00);
        applyStimulus("ckCmt3",    0, 5'd0, 4'd0, 1, 5'd3, 4'd4, 5'd3, 5'd0, 5'h18, 5'h00);
        pendRestore = 1'b1; pendRestoreId = 2'd1;
        applyStimulus("ckRest1",   0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd3, 5'd0, 5'h18, 5'h00);
        applyStimulus("ckFree3",   0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd3, 5'd0, 5'h00, 5'h00);
        applyStimulus("ckIss6",    1, 5'd6, 4'd2, 0, 5'd0, 4'd0, 5'd6, 5'd0, 5'h00, 5'h00);
        pendRestore = 1'b1; pendRestoreId = 2'd1; pendSave = 1'b1; pendSaveId = 2'd2;
        applyStimulus("ckSvRst",   1, 5'd6, 4'd11, 0, 5'd0, 4'd0, 5'd6, 5'd0, 5'h12, 5'h00);
        applyStimulus("ckDrop6",   0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd6, 5'd0, 5'h00, 5'h00);
        pendRestore = 1'b1; pendRestoreId = 2'd2;
        applyStimulus("ckRest2",   0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd6, 5'd0, 5'h00, 5'h00);
        applyStimulus("ckImg2",    0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd6, 5'd0, 5'h00, 5'h00);
        applyStimulus("ckIss8",    1, 5'd8, 4'd5, 0, 5'd0, 4'd0, 5'd8, 5'd0, 5'h00, 5'h00);
        pendRestore = 1'b1; pendRestoreId = 2'd3;
        applyStimulus("ckRest3",   0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd8, 5'd0, 5'h15, 5'h00);
        applyStimulus("ckEmpty3",  0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd8, 5'd0, 5'h00, 5'h00);
        pendSave = 1'b1; pendSaveId = 2'd0;
        applyStimulus("ckSave0",   1, 5'd10, 4'd7, 0, 5'd0, 4'd0, 5'd10, 5'd0, 5'h00, 5'h00);
        pendFlush = 1'b1; pendRestore = 1'b1; pendRestoreId = 2'd0;
        applyStimulus("ckFlush",   1, 5'd2, 4'd1, 0, 5'd0, 4'd0, 5'd10, 5'd2, 5'h17, 5'h00);
        pendRestore = 1'b1; pendRestoreId = 2'd0;
        applyStimulus("ckRestFl",  0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd10, 5'd2, 5'h00, 5'h00);
        applyStimulus("ckSlotFl",  0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd10, 5'd2, 5'h00, 5'h00);
`endif

        // Random issue/commit traffic against a reference table
        for (int n = 0; n < 200; n++) begin
            logic       iv, cv;
            logic [4:0] id, cd, s1, s2;
            logic [3:0] ir, cr;
            iv = 1'($urandom_range(0, 1));
            id = 5'($urandom_range(0, 7));
            ir = 4'($urandom_range(0, 15));
            cv = 1'($urandom_range(0, 1));
            cd = 5'($urandom_range(0, 7));
            cr = ($urandom_range(0, 3) != 0) ? mRob[cd] : 4'($urandom_range(0, 15));
            s1 = ($urandom_range(0, 1) != 0) ? cd : 5'($urandom_range(0, 7));
            s2 = 5'($urandom_range(0, 7));
            applyStimulus("rand", iv, id, ir, cv, cd, cr, s1, s2,
                          modelRead(s1, cv, cd, cr), modelRead(s2, cv, cd, cr));
            if (cv && cd != 5'd0 && mRob[cd] == cr) begin
                mBusy[cd] = 1'b0;
                mRob[cd]  = '0;
            end
            if (iv && id != 5'd0) begin
                mBusy[id] = 1'b1;
                mRob[id]  = ir;
            end
        end

        // Asynchronous reset clears a busy entry without a clock edge
        pendFlush = 1'b1;
        applyStimulus("preFlush",  0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd0, 5'd0, 5'h00, 5'h00);
        applyStimulus("iss9",      1, 5'd9, 4'd7, 0, 5'd0, 4'd0, 5'd9, 5'd0, 5'h00, 5'h00);
        applyStimulus("read9",     0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 5'd9, 5'd9, 5'h17, 5'h17);
        #2 reset_n = 1'b0;
        e.tag = "asyncRst"; e.expJ = 5'h00; e.expK = 5'h00;
        sbQueue.push_back(e);
        sampleCheck();
        @(negedge clk);
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regstat_ckpt.md
REGSTAT_CKPT -- requirements
Module: regstat_ckpt

Interface
- REQ-001 SHALL have parameter NUM_REGS, default 32: number of architectural registers; register 0 is hardwired not-busy.
- REQ-002 SHALL have parameter ROB_DEPTH, default 16: number of ROB entries; ROB_IDX_W = clog2(ROB_DEPTH).
- REQ-003 SHALL have parameter NUM_CKPT, default 4: number of branch checkpoints; CKPT_IDX_W = clog2(NUM_CKPT).
- REQ-004 SHALL have port clk, input, 1: single clock; all state changes on posedge.
- REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
- REQ-006 SHALL have port flush, input, 1: mispredicted branch committed; clears the whole table.
- REQ-007 SHALL have ports issue_valid (in, 1), issue_dest (in, REG_IDX_W) and issue_rob (in, ROB_IDX_W): issued instruction claims issue_dest.
- REQ-008 SHALL have ports commit_valid (in, 1; RegWrite of the committing instruction), commit_dest (in, REG_IDX_W) and commit_rob (in, ROB_IDX_W).
- REQ-009 SHALL have ports rs1 and rs2 (in, REG_IDX_W): source operands of the instruction in issue.
- REQ-010 SHALL have ports q_j and q_k (out, ROB_IDX_W): producer ROB tags; ports busy_j and busy_k (out, 1): operand not yet committed.
- REQ-011 SHALL have ports ckpt_save (in, 1), ckpt_save_id (in, CKPT_IDX_W), ckpt_restore (in, 1) and ckpt_restore_id (in, CKPT_IDX_W); these exist only with REGSTAT_CKPT_EN defined.

Function
- REQ-012 SHALL provide combinational reads: {busy_j, q_j} = table[rs1] and {busy_k, q_k} = table[rs2], taken from current register state (pre-update).
- REQ-013 SHALL return busy=0 and q=0 for a source index of 0.
- REQ-014 SHALL apply a same-cycle commit bypass on reads: if commit_valid and commit_dest==rsX and table[rsX].rob==commit_rob, busy_X SHALL read 0.
- REQ-015 SHALL, on issue_valid with issue_dest!=0, write {busy=1, rob=issue_rob} to table[issue_dest] at the next edge.
- REQ-016 SHALL, on commit_valid with commit_dest!=0, clear table[commit_dest] only if its rob equals commit_rob; otherwise the entry is unchanged.
- REQ-017 SHALL give issue priority over commit when both target the same register in the same cycle.
- REQ-018 SHALL give per-cycle priority flush > ckpt_restore > {issue, commit}.
- REQ-019 SHALL, on flush, clear all table entries and all checkpoints at the next edge, ignoring every other input.
- REQ-020 SHALL, on ckpt_save, copy the post-update table (this cycle's issue and commit applied) into slot ckpt_save_id; saving an occupied slot overwrites it.
- REQ-021 SHALL, on every commit, also clear matching {dest, rob} entries in all checkpoint slots in the same cycle.
- REQ-022 SHALL, on ckpt_restore, load the table from slot ckpt_restore_id with this cycle's commit clear applied; the same-cycle issue SHALL be dropped.
- REQ-023 SHALL save the incoming restored image, not the old table, when ckpt_save and ckpt_restore occur in the same cycle.
- REQ-024 SHALL produce a cleared table when restoring a slot that was never saved since reset.

Reset
- REQ-025 SHALL, while reset_n=0, clear every table entry and checkpoint slot asynchronously, so that all busy_*=0 and all q_*=0.
- REQ-026 SHALL take effect on the first clk edge after reset_n deasserts, with no dead cycle.

Configuration
- REQ-027 SHALL build checkpoint storage, ports and REQ-020..024 only when REGSTAT_CKPT_EN is defined; without it, recovery relies only on flush.

Structure
- REQ-028 SHALL define the parametrised reg_stat_t {busy, rob} and the REG_IDX_W, ROB_IDX_W and CKPT_IDX_W constants in shared package ooo_pkg.
- REQ-029 SHALL implement the checkpoint slots, including the commit-clear logic, in the single sub-module regstat_ckpt_bank.

Verification
- REQ-030 SHALL cover: issue dest=5 rob=3, next cycle rs1=5 -> busy_j=1, q_j=3; then commit dest=5 rob=3 -> same-cycle busy_j=0, entry cleared next cycle.
- REQ-031 SHALL cover: issue dest=7 rob=2, then issue dest=7 rob=9, then commit dest=7 rob=2 -> entry stays {1,9}.
- REQ-032 SHALL cover: same-cycle issue dest=4 rob=6 and commit dest=4 rob=1 (entry held rob 1) -> entry becomes {1,6}.
- REQ-033 SHALL cover: issue dest=0 rob=5 -> rs1=0 reads busy_j=0, q_j=0.
- REQ-034 SHALL cover: save slot 1 holding r3={1,4}, issue r3 rob=8, commit r3 rob=4, restore slot 1 -> r3 not busy.
- REQ-035 SHALL cover: flush asserted together with issue dest=2 and ckpt_restore -> all entries and all slots clear next cycle.
